// File: rtl/inverter_sweep_seq_if.sv
// Control/result bundle between the tile top and the inverter sweep sequencer.
// The analog-side pins (sel, drive_en, sample, cmp_in) stay as plain ports on the sequencer.
interface inverter_sweep_seq_if #(
  parameter int SEL_W   = 3,
  parameter int SMP_LOG = 4
);
  logic               start;
  logic [7:0]         settle_cycles;
  logic               busy;
  logic [SMP_LOG:0]   result;
  logic [SEL_W-1:0]   result_sel;
  logic               result_valid;
  logic               done;

  modport master (
    output start, settle_cycles,
    input  busy, result, result_sel, result_valid, done
  );

  modport slave (
    input  start, settle_cycles,
    output busy, result, result_sel, result_valid, done
  );
endinterface

// File: rtl/inverter_sweep_seq.sv
// Sweeps the analog mux select through every code, settles, counts high comparator
// samples over a fixed window and reports one result per code, then a done strobe.
//
//   state  | meaning
//   IDLE   | waiting for start with ena high
//   SETTLE | drive on, counting down the settle time for the current sel
//   SAMPLE | 2**SMP_LOG cycles accumulating synchronised comparator highs
//   REPORT | one cycle: result strobe, then next sel or back to IDLE
module inverter_sweep_seq #(
  parameter int SEL_W   = 3,
  parameter int SMP_LOG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmp_in,
  output logic [SEL_W-1:0] sel,
  output logic             drive_en,
  output logic             sample,
  inverter_sweep_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

  localparam logic [7:0]       SMP_LAST = 8'((2 ** SMP_LOG) - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = '1;

  state_t             state;
  logic [7:0]         cnt;
  logic [SMP_LOG:0]   acc;
  logic [SMP_LOG:0]   acc_sum;
  logic               cmp_meta;
  logic               cmp_s;
  logic               busy_q;
  logic [SMP_LOG:0]   result_q;
  logic [SEL_W-1:0]   result_sel_q;
  logic               result_valid_q;
  logic               done_q;

  // Includes the current sample so the last SAMPLE cycle is counted in the result.
  assign acc_sum = acc + {{SMP_LOG{1'b0}}, cmp_s};

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_sel   = result_sel_q;
  assign bus.result_valid = result_valid_q;
  assign bus.done         = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      cmp_meta       <= 1'b0;
      cmp_s          <= 1'b0;
      sel            <= '0;
      drive_en       <= 1'b0;
      sample         <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_sel_q   <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      cmp_meta       <= cmp_in;
      cmp_s          <= cmp_meta;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;

      if (!ena) begin
        // Abort: result/result_sel deliberately hold the last reported value.
        state    <= IDLE;
        sel      <= '0;
        drive_en <= 1'b0;
        sample   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= SETTLE;
              sel      <= '0;
              cnt      <= bus.settle_cycles;
              acc      <= '0;
              drive_en <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          SETTLE: begin
            if (cnt == 8'd0) begin
              state  <= SAMPLE;
              cnt    <= SMP_LAST;
              sample <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          SAMPLE: begin
            acc <= acc_sum;
            if (cnt == 8'd0) begin
              state          <= REPORT;
              sample         <= 1'b0;
              result_q       <= acc_sum;
              result_sel_q   <= sel;
              result_valid_q <= 1'b1;
              done_q         <= (sel == SEL_LAST);
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          REPORT: begin
            if (sel == SEL_LAST) begin
              state    <= IDLE;
              sel      <= '0;
              drive_en <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              state <= SETTLE;
              sel   <= sel + 1'b1;
              acc   <= '0;
              cnt   <= bus.settle_cycles;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inverter_sweep_seq.sv
// Directed bench for inverter_sweep_seq: full sweeps with constant and toggling
// comparator input, ena abort, start-while-busy, and asynchronous reset mid-sample.
module tb_inverter_sweep_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmp_in;
  logic [2:0] sel;
  logic       drive_en;
  logic       sample;

  inverter_sweep_seq_if #(.SEL_W(3), .SMP_LOG(4)) bus ();

  inverter_sweep_seq #(.SEL_W(3), .SMP_LOG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .cmp_in   (cmp_in),
    .sel      (sel),
    .drive_en (drive_en),
    .sample   (sample),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stb_cyc [16];
  int stb_res [16];
  int stb_sel [16];
  int nstb;
  int ndone;
  int done_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 = cmp low, 1 = cmp high, 2 = cmp toggles every cycle.
  // n counts clock edges since start was sampled (n=1 right after that edge).
  task automatic run(input int settle, input int mode, input int pulse_n,
                     input int abort_n, input int max_n);
    int n;
    ena = 1'b1;
    bus.settle_cycles = 8'(settle);
    cmp_in = (mode == 1);
    nstb = 0;
    ndone = 0;
    done_n = -10;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (n <= max_n) begin
      if (n == 1) begin
        chk("busy_first", 32'(bus.busy), 1);
        chk("drive_first", 32'(drive_en), 1);
        chk("sel_first", 32'(sel), 0);
        chk("sample_in_settle", 32'(sample), 0);
      end
      if (n == settle + 2) chk("sample_first", 32'(sample), 1);
      if (bus.result_valid) begin
        if (nstb < 16) begin
          stb_cyc[nstb] = n;
          stb_res[nstb] = int'(bus.result);
          stb_sel[nstb] = int'(bus.result_sel);
        end
        nstb++;
      end
      if (bus.done) begin
        ndone++;
        done_n = n;
      end
      if (ndone > 0 && n == done_n + 1) chk("busy_after_done", 32'(bus.busy), 0);
      if (abort_n > 0 && n == abort_n + 1) begin
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_drive", 32'(drive_en), 0);
        chk("abort_sample", 32'(sample), 0);
        chk("abort_sel", 32'(sel), 0);
        chk("abort_result", 32'(bus.result), 16);
        chk("abort_result_sel", 32'(bus.result_sel), 2);
      end
      if (n == abort_n) ena = 1'b0;
      bus.start = (n == pulse_n);
      if (mode == 2) cmp_in = ~cmp_in;
      tick();
      n++;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input int period, input int res);
    chk({tag, "_strobes"}, 32'(nstb), 8);
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_cyc"}, 32'(stb_cyc[k]), 32'(period * (k + 1)));
      chk({tag, "_res"}, 32'(stb_res[k]), 32'(res));
      chk({tag, "_sel"}, 32'(stb_sel[k]), 32'(k));
    end
    chk({tag, "_done_cnt"}, 32'(ndone), 1);
    chk({tag, "_done_cyc"}, 32'(done_n), 32'(period * 8));
  endtask

  initial begin
    int vld_seen;
    int busy_seen;
    rst_n = 1'b0;
    ena = 1'b1;
    cmp_in = 1'b0;
    bus.start = 1'b0;
    bus.settle_cycles = 8'd0;
    repeat (2) tick();

    chk("rst_sel", 32'(sel), 0);
    chk("rst_drive", 32'(drive_en), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_result_sel", 32'(bus.result_sel), 0);
    chk("rst_valid", 32'(bus.result_valid), 0);
    chk("rst_done", 32'(bus.done), 0);

    rst_n = 1'b1;
    tick();

    // settle=3, cmp high, start pulsed again during SETTLE of sel=1 (edge 24).
    run(3, 1, 23, -1, 175);
    check_sweep("sweep_high", 21, 16);

    // settle=0, cmp toggling: 8 highs in every 16-sample window.
    run(0, 2, -1, -1, 150);
    check_sweep("sweep_toggle", 18, 8);

    // Asynchronous reset in the middle of SAMPLE for sel=0.
    bus.settle_cycles = 8'd3;
    cmp_in = 1'b1;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_sample", 32'(sample), 1);
    chk("pre_rst_result", 32'(bus.result), 8);
    rst_n = 1'b0;
    #2;
    chk("arst_sel", 32'(sel), 0);
    chk("arst_drive", 32'(drive_en), 0);
    chk("arst_sample", 32'(sample), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_result", 32'(bus.result), 0);
    chk("arst_result_sel", 32'(bus.result_sel), 0);
    tick();
    rst_n = 1'b1;
    vld_seen = 0;
    busy_seen = 0;
    repeat (40) begin
      tick();
      if (bus.result_valid || bus.done) vld_seen++;
      if (bus.busy) busy_seen++;
    end
    chk("post_rst_strobes", 32'(vld_seen), 0);
    chk("post_rst_busy", 32'(busy_seen), 0);

    // ena dropped at edge 71 while sel=3 is sampling.
    run(3, 1, -1, 70, 110);
    chk("abort_strobes", 32'(nstb), 3);
    chk("abort_done", 32'(ndone), 0);

    // Clean restart after abort, cmp low: every result 0.
    run(3, 0, -1, -1, 175);
    check_sweep("sweep_low", 21, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
